// File: rtl/lcd1602_cmd_sched.sv
`default_nettype none
// lcd1602_cmd_sched: HD44780 bus sequencer with power-up init and a command FIFO.
// Optional LCD_BUSY_POLL_EN replaces fixed execution waits with busy-flag polling.
module lcd1602_cmd_sched #(
  parameter int FIFO_DEPTH   = 4,
  parameter int T_PWRUP      = 20,
  parameter int T_SETUP      = 2,
  parameter int T_EN         = 4,
  parameter int T_HOLD       = 2,
  parameter int T_WAIT_SHORT = 10,
  parameter int T_WAIT_LONG  = 40
) (
  input  logic                          pclk,
  input  logic                          presetn,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_rs,
  input  logic [7:0]                    cmd_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          init_done,
  output logic                          busy,
  output logic                          lcd_en,
  output logic                          lcd_rw,
  output logic                          lcd_rs,
  output logic [7:0]                    lcd_data_o,
  output logic                          lcd_data_oe,
  input  logic [7:0]                    lcd_data_i
);

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LW    = AW + 1;
  localparam int T_MAX = imax(imax(imax(T_PWRUP, T_SETUP), imax(T_EN, T_HOLD)),
                              imax(T_WAIT_SHORT, T_WAIT_LONG));
  localparam int CW    = $clog2(T_MAX + 2);

  // A state lasts max(T,1) cycles, so it exits once cnt reaches T-1 (0 for T<=1).
  function automatic logic [CW-1:0] last_of(input int t);
    return (t <= 1) ? '0 : CW'(t - 1);
  endfunction

  localparam logic [CW-1:0] L_PWRUP = last_of(T_PWRUP);
  localparam logic [CW-1:0] L_SETUP = last_of(T_SETUP);
  localparam logic [CW-1:0] L_EN    = last_of(T_EN);
  localparam logic [CW-1:0] L_HOLD  = last_of(T_HOLD);
  localparam logic [CW-1:0] L_WLONG = last_of(T_WAIT_LONG);

  typedef enum logic [3:0] {
    ST_PWRUP, ST_LOAD, ST_IDLE, ST_SETUP, ST_EN_HI, ST_HOLD, ST_WAIT,
    ST_POLL_SETUP, ST_POLL_EN, ST_POLL_HOLD
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic [2:0]    init_cnt;
  logic          rs_q;
  logic [7:0]    data_q;
  logic          bf_q;
  logic [CW-1:0] wait_last;
  logic          cmd_done;
  logic          poll_phase;

  logic [8:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push, pop, fifo_empty;

  logic unused_data_i;
  assign unused_data_i = ^lcd_data_i;

  function automatic logic [7:0] init_rom(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h06;
      default: return 8'h01;
    endcase
  endfunction

  assign fifo_empty = (fifo_level == '0);
  assign cmd_ready  = (fifo_level != LW'(FIFO_DEPTH));
  assign push       = cmd_valid && cmd_ready;
  assign pop        = (state == ST_LOAD) && init_done && !fifo_empty;

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (push) mem[wr_ptr] <= {cmd_rs, cmd_data};
  end

`ifdef LCD_BUSY_POLL_EN
  // Only the first init command (before BF is meaningful) takes a fixed wait.
  assign wait_last = L_WLONG;
`else
  localparam logic [CW-1:0] L_WSHORT = last_of(T_WAIT_SHORT);
  assign wait_last = (!rs_q && (data_q == 8'h01 || data_q == 8'h02 || data_q == 8'h03))
                     ? L_WLONG : L_WSHORT;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      ST_PWRUP: if (cnt >= L_PWRUP) state_nx = ST_LOAD;
      ST_LOAD:  state_nx = (!init_done || !fifo_empty) ? ST_SETUP : ST_IDLE;
      ST_IDLE:  if (!fifo_empty) state_nx = ST_LOAD;
      ST_SETUP: if (cnt >= L_SETUP) state_nx = ST_EN_HI;
      ST_EN_HI: if (cnt >= L_EN) state_nx = ST_HOLD;
      ST_HOLD: begin
        if (cnt >= L_HOLD) begin
`ifdef LCD_BUSY_POLL_EN
          state_nx = (init_cnt == 3'd1 && !init_done) ? ST_WAIT : ST_POLL_SETUP;
`else
          state_nx = ST_WAIT;
`endif
        end
      end
      ST_WAIT:  if (cnt >= wait_last) state_nx = ST_LOAD;
`ifdef LCD_BUSY_POLL_EN
      ST_POLL_SETUP: if (cnt >= L_SETUP) state_nx = ST_POLL_EN;
      ST_POLL_EN:    if (cnt >= L_EN) state_nx = ST_POLL_HOLD;
      ST_POLL_HOLD:  if (cnt >= L_HOLD) state_nx = bf_q ? ST_POLL_SETUP : ST_LOAD;
`endif
      default:  state_nx = ST_PWRUP;
    endcase
  end

  assign cmd_done = (state_nx == ST_LOAD) && ((state == ST_WAIT) || (state == ST_POLL_HOLD));

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state     <= ST_PWRUP;
      cnt       <= '0;
      init_cnt  <= '0;
      init_done <= 1'b0;
      rs_q      <= 1'b0;
      data_q    <= 8'h00;
      bf_q      <= 1'b0;
    end else begin
      state <= state_nx;
      if (state_nx != state) cnt <= '0;
      else if (cnt != '1)    cnt <= cnt + 1'b1;

      if (state == ST_LOAD && state_nx == ST_SETUP) begin
        if (!init_done) begin
          rs_q     <= 1'b0;
          data_q   <= init_rom(init_cnt[1:0]);
          init_cnt <= init_cnt + 3'd1;
        end else begin
          {rs_q, data_q} <= mem[rd_ptr];
        end
      end

      if (cmd_done && init_cnt == 3'd4) init_done <= 1'b1;
      if (state == ST_POLL_EN && state_nx != ST_POLL_EN) bf_q <= lcd_data_i[7];
    end
  end

  assign poll_phase  = (state == ST_POLL_SETUP) || (state == ST_POLL_EN) ||
                       (state == ST_POLL_HOLD);
  assign lcd_en      = (state == ST_EN_HI) || (state == ST_POLL_EN);
`ifdef LCD_BUSY_POLL_EN
  assign lcd_rw      = poll_phase;
`else
  assign lcd_rw      = 1'b0;
`endif
  assign lcd_rs      = poll_phase ? 1'b0 : rs_q;
  assign lcd_data_o  = data_q;
  assign lcd_data_oe = (state == ST_SETUP) || (state == ST_EN_HI) || (state == ST_HOLD);
  assign busy        = (state != ST_IDLE) || !fifo_empty;

endmodule
`default_nettype wire

// File: tb/tb_lcd1602_cmd_sched.sv
`default_nettype none
// tb_lcd1602_cmd_sched: directed checks of init timing, FIFO flow, waits and reset.
module tb_lcd1602_cmd_sched;

  logic       pclk = 1'b0;
  logic       presetn;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_rs;
  logic [7:0] cmd_data;
  logic [2:0] fifo_level;
  logic       init_done;
  logic       busy;
  logic       lcd_en;
  logic       lcd_rw;
  logic       lcd_rs;
  logic [7:0] lcd_data_o;
  logic       lcd_data_oe;
  logic [7:0] lcd_data_i;

  lcd1602_cmd_sched dut (
    .pclk        (pclk),
    .presetn     (presetn),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_rs      (cmd_rs),
    .cmd_data    (cmd_data),
    .fifo_level  (fifo_level),
    .init_done   (init_done),
    .busy        (busy),
    .lcd_en      (lcd_en),
    .lcd_rw      (lcd_rw),
    .lcd_rs      (lcd_rs),
    .lcd_data_o  (lcd_data_o),
    .lcd_data_oe (lcd_data_oe),
    .lcd_data_i  (lcd_data_i)
  );

  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Strobe monitor, sampled on the falling edge
  int         s_cyc[$];
  logic [7:0] s_data[$];
  logic       s_rs[$];
  logic       s_rw[$];
  logic       s_oe[$];
  int         s_wid[$];
  int         en_len = 0;
  int         init_rise = -1;
  int         busy_fall = -1;
  logic       prev_en = 1'b0, prev_init = 1'b0, prev_busy = 1'b0;

  always @(negedge pclk) begin
    if (lcd_en && !prev_en) begin
      s_cyc.push_back(cyc);
      s_data.push_back(lcd_data_o);
      s_rs.push_back(lcd_rs);
      s_rw.push_back(lcd_rw);
      s_oe.push_back(lcd_data_oe);
      en_len = 0;
    end
    if (lcd_en) en_len++;
    if (!lcd_en && prev_en) s_wid.push_back(en_len);
    if (init_done && !prev_init) init_rise = cyc;
    if (!busy && prev_busy) busy_fall = cyc;
    prev_en   = lcd_en;
    prev_init = init_done;
    prev_busy = busy;
  end

  task automatic push(input logic rs, input logic [7:0] d, output int acc);
    @(negedge pclk);
    cmd_valid = 1'b1;
    cmd_rs    = rs;
    cmd_data  = d;
    for (int i = 0; i < 1000 && !cmd_ready; i++) @(negedge pclk);
    if (!cmd_ready) check_eq("push_ready_timeout", {31'd0, cmd_ready}, 32'd1);
    @(posedge pclk);
    #1;
    acc       = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_strobes(input int n, input string tag);
    for (int i = 0; i < 3000 && s_cyc.size() < n; i++) @(negedge pclk);
    @(negedge pclk);
    check_eq(tag, s_cyc.size(), n);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 3000 && busy; i++) @(negedge pclk);
    @(negedge pclk);
    check_eq(tag, {31'd0, busy}, 32'd0);
  endtask

  logic [7:0] init_exp [4] = '{8'h38, 8'h0C, 8'h06, 8'h01};
  logic [7:0] seq3_exp [3] = '{8'h01, 8'h80, 8'h42};

  initial begin
    #500000;
    $display("FAIL watchdog: run still active at %0t, expected completion", $time);
    $fatal(1);
  end

  initial begin
    int rel, rel2, base, e, e1, e2, e3, e4, e5;
    presetn    = 1'b0;
    cmd_valid  = 1'b0;
    cmd_rs     = 1'b0;
    cmd_data   = 8'h00;
    lcd_data_i = 8'h00;

    repeat (3) @(posedge pclk);
    @(negedge pclk);
    check_eq("rst_en",    {31'd0, lcd_en},      32'd0);
    check_eq("rst_rw",    {31'd0, lcd_rw},      32'd0);
    check_eq("rst_rs",    {31'd0, lcd_rs},      32'd0);
    check_eq("rst_data",  {24'd0, lcd_data_o},  32'h00);
    check_eq("rst_oe",    {31'd0, lcd_data_oe}, 32'd0);
    check_eq("rst_init",  {31'd0, init_done},   32'd0);
    check_eq("rst_busy",  {31'd0, busy},        32'd1);
    check_eq("rst_level", {29'd0, fifo_level},  32'd0);
    check_eq("rst_ready", {31'd0, cmd_ready},   32'd1);

    // Release; the edge that still samples reset low is cycle 0
    @(posedge pclk);
    #1;
    presetn = 1'b1;
    rel     = cyc;

    wait_strobes(4, "init_strobe_count");
    check_eq("init_first_en_cyc", s_cyc[0] - rel, 23);
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("init_data_%0d", k), {24'd0, s_data[k]}, {24'd0, init_exp[k]});
      if (k > 0) check_eq($sformatf("init_gap_%0d", k), s_cyc[k] - s_cyc[k-1], 19);
    end
    wait_idle("init_idle");
    check_eq("init_done_cyc", init_rise - rel, 126);
    check_eq("init_done_lvl", {31'd0, init_done}, 32'd1);

    // Single data write after init
    base = s_cyc.size();
    push(1'b1, 8'h41, e);
    wait_idle("wr41_idle");
    check_eq("wr41_count", s_cyc.size(), base + 1);
    check_eq("wr41_en_cyc", s_cyc[base] - e, 4);
    check_eq("wr41_width", s_wid[base], 4);
    check_eq("wr41_rs", {31'd0, s_rs[base]}, 32'd1);
    check_eq("wr41_rw", {31'd0, s_rw[base]}, 32'd0);
    check_eq("wr41_oe", {31'd0, s_oe[base]}, 32'd1);
    check_eq("wr41_data", {24'd0, s_data[base]}, 32'h41);
    check_eq("wr41_busy_fall", busy_fall - e, 21);

    // Clear (long wait) then set-DDRAM (short wait)
    base = s_cyc.size();
    push(1'b0, 8'h01, e1);
    push(1'b0, 8'h80, e2);
    push(1'b1, 8'h42, e3);
    check_eq("seq3_b2b", e2 - e1, 1);
    wait_strobes(base + 3, "seq3_count");
    wait_idle("seq3_idle");
    check_eq("seq3_first_cyc", s_cyc[base] - e1, 4);
    check_eq("seq3_gap_clear", s_cyc[base+1] - s_cyc[base], 49);
    check_eq("seq3_gap_80", s_cyc[base+2] - s_cyc[base+1], 19);
    for (int k = 0; k < 3; k++)
      check_eq($sformatf("seq3_data_%0d", k), {24'd0, s_data[base+k]}, {24'd0, seq3_exp[k]});

    // Reset while a user command has lcd_en high
    push(1'b1, 8'h55, e1);
    push(1'b1, 8'h56, e2);
    push(1'b1, 8'h57, e3);
    for (int i = 0; i < 200 && !lcd_en; i++) @(negedge pclk);
    check_eq("mid_en_high", {31'd0, lcd_en}, 32'd1);
    check_eq("mid_data", {24'd0, lcd_data_o}, 32'h55);
    check_eq("mid_level", {29'd0, fifo_level}, 32'd2);
    presetn = 1'b0;
    @(negedge pclk);
    check_eq("mid_rst_en", {31'd0, lcd_en}, 32'd0);
    check_eq("mid_rst_level", {29'd0, fifo_level}, 32'd0);
    check_eq("mid_rst_init", {31'd0, init_done}, 32'd0);
    check_eq("mid_rst_oe", {31'd0, lcd_data_oe}, 32'd0);
    @(posedge pclk);
    @(posedge pclk);
    #1;
    presetn = 1'b1;
    rel2    = cyc;

    // Five pushes during power-up into a 4-deep FIFO
    base = s_cyc.size();
    push(1'b1, 8'h61, e1);
    push(1'b1, 8'h62, e2);
    push(1'b1, 8'h63, e3);
    push(1'b1, 8'h64, e4);
    check_eq("full_b2b", e4 - e1, 3);
    check_eq("full_ready", {31'd0, cmd_ready}, 32'd0);
    check_eq("full_level", {29'd0, fifo_level}, 32'd4);
    push(1'b1, 8'h65, e5);
    check_eq("fifth_accept_cyc", e5 - rel2, 128);
    wait_strobes(base + 9, "reinit_count");
    check_eq("reinit_first_cyc", s_cyc[base] - rel2, 23);
    for (int k = 0; k < 4; k++)
      check_eq($sformatf("reinit_data_%0d", k), {24'd0, s_data[base+k]}, {24'd0, init_exp[k]});
    check_eq("reinit_done_cyc", init_rise - rel2, 126);
    for (int k = 0; k < 5; k++) begin
      check_eq($sformatf("q5_data_%0d", k), {24'd0, s_data[base+4+k]}, 32'h61 + k);
      check_eq($sformatf("q5_rs_%0d", k), {31'd0, s_rs[base+4+k]}, 32'd1);
    end
    wait_idle("final_idle");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
